// File: rtl/print_ps_pkg.sv
// Shared definitions for the PS-side print receiver: the handshake FSM
// state encoding and the layout of a buffered FIFO entry.
// A FIFO entry is {eom, word}, so the EOM flag sits just above the data word.
package print_ps_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_e;

    // Width of one FIFO entry: data word plus the EOM bit.
    function automatic int entry_w(input int data_w);
        return data_w + 1;
    endfunction

    // Bit position of the EOM flag inside a FIFO entry.
    function automatic int eom_idx(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/print_ps_fifo.sv
// Synchronous first-word fall-through FIFO. The head entry is presented
// combinationally from storage. Writes while full and reads while empty are
// ignored. Storage is not reset; only pointers and occupancy are.
module print_ps_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Entry storage: data path only, never reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); occupancy tracks push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/print_ps_receiver.sv
// PS-side end of the SoC print channel. Each word offered on print_ps_en_i is
// stored as {done, data} and acknowledged with a one-cycle print_ps_finish_o.
// Build option PRINT_RX_DROP_EN: words arriving while the FIFO is full are
// discarded and counted (drop_cnt_o) instead of stalling the SoC.
module print_ps_receiver
    import print_ps_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_W     = 32,
    parameter int DROP_CNT_W = 16
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_sys_i,
    input  logic                     print_ps_en_i,
    input  logic [DATA_W-1:0]        print_ps_data_i,
    input  logic                     print_ps_done_i,
    output logic                     print_ps_finish_o,
    output logic                     rd_valid_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_eom_o,
    input  logic                     rd_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef PRINT_RX_DROP_EN
    ,
    output logic [DROP_CNT_W-1:0]    drop_cnt_o
`endif
);

    localparam int EW  = entry_w(DATA_W);
    localparam int EOM = eom_idx(DATA_W);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("print_ps_receiver: DEPTH must be a power of two >= 2");
    end
    if (DROP_CNT_W < 1) begin : g_bad_drop_w
        $error("print_ps_receiver: DROP_CNT_W must be >= 1");
    end

    state_e        state;
    state_e        state_nxt;
    logic          wr_en;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] head;
`ifdef PRINT_RX_DROP_EN
    logic          drop_hit;
`endif

    print_ps_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk_sys_i),
        .rst     (rst_sys_i),
        .wr_en   (wr_en),
        .wr_data ({print_ps_done_i, print_ps_data_i}),
        .rd_en   (rd_ready_i),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count_o)
    );

    assign rd_valid_o        = !fifo_empty;
    assign rd_data_o         = head[DATA_W-1:0];
    assign rd_eom_o          = head[EOM];
    assign print_ps_finish_o = (state == ST_ACK);

    // Handshake state register.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and FIFO write gating; a full FIFO either stalls or drops.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
`ifdef PRINT_RX_DROP_EN
        drop_hit  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (print_ps_en_i) begin
                    if (!fifo_full) begin
                        wr_en     = 1'b1;
                        state_nxt = ST_ACK;
                    end
`ifdef PRINT_RX_DROP_EN
                    else begin
                        drop_hit  = 1'b1;
                        state_nxt = ST_ACK;
                    end
`endif
                end
            end
            ST_ACK: begin
                state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!print_ps_en_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef PRINT_RX_DROP_EN
    // Saturating count of words discarded because the FIFO was full.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            drop_cnt_o <= '0;
        end else if (drop_hit && (drop_cnt_o != '1)) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_print_ps_receiver.sv
// Self-checking bench for print_ps_receiver: directed scenarios followed by
// randomized SoC/reader traffic, all compared against a message-level model.
module tb_print_ps_receiver;

    localparam int DEPTH      = 16;
    localparam int DATA_W     = 32;
    localparam int DROP_CNT_W = 16;
`ifdef PRINT_RX_DROP_EN
    localparam bit DROP_MODE  = 1'b1;
`else
    localparam bit DROP_MODE  = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              done = 1'b0;
    logic              finish;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_eom;
    logic              rd_ready = 1'b0;
    logic [4:0]        count;
`ifdef PRINT_RX_DROP_EN
    logic [DROP_CNT_W-1:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: buffered entries, acknowledge/handshake phase, drops.
    logic [DATA_W:0] q[$];
    bit              m_ack  = 1'b0;
    bit              m_wait = 1'b0;
    int              m_drops = 0;

    print_ps_receiver #(
        .DEPTH      (DEPTH),
        .DATA_W     (DATA_W),
        .DROP_CNT_W (DROP_CNT_W)
    ) dut (
        .clk_sys_i         (clk),
        .rst_sys_i         (rst),
        .print_ps_en_i     (en),
        .print_ps_data_i   (data),
        .print_ps_done_i   (done),
        .print_ps_finish_o (finish),
        .rd_valid_o        (rd_valid),
        .rd_data_o         (rd_data),
        .rd_eom_o          (rd_eom),
        .rd_ready_i        (rd_ready),
        .count_o           (count)
`ifdef PRINT_RX_DROP_EN
        ,
        .drop_cnt_o        (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply the receiver's rules to the inputs presented this cycle.
    task automatic model_step();
        bit idle, full, take, pop, nxt_wait;
        if (rst) begin
            q.delete();
            m_ack   = 1'b0;
            m_wait  = 1'b0;
            m_drops = 0;
        end else begin
            idle     = !m_ack && !m_wait;
            full     = (q.size() == DEPTH);
            pop      = rd_ready && (q.size() > 0);
            take     = idle && en && (!full || DROP_MODE);
            nxt_wait = m_ack || (m_wait && en);
            if (take && full && (m_drops < (1 << DROP_CNT_W) - 1)) m_drops++;
            if (pop) void'(q.pop_front());
            if (take && !full) q.push_back({done, data});
            m_ack  = take;
            m_wait = nxt_wait;
        end
    endtask

    // One clock: model update, edge, then compare all outputs 1ns later.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("finish", finish, m_ack);
        check_eq("rd_valid", rd_valid, q.size() > 0);
        check_eq("count", count, q.size());
        if (q.size() > 0) begin
            check_eq("rd_data", rd_data, q[0][DATA_W-1:0]);
            check_eq("rd_eom", rd_eom, q[0][DATA_W]);
        end
`ifdef PRINT_RX_DROP_EN
        check_eq("drop_cnt", drop_cnt, m_drops);
`endif
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic dn);
        int b;
        en   = 1'b1;
        data = d;
        done = dn;
        tick();
        b = 0;
        while (!finish && b < 40) begin
            tick();
            b++;
        end
        if (b == 40) check_eq("ack_timeout", finish, 1);
        en = 1'b0;
        tick();
        tick();
    endtask

    task automatic drain();
        int b;
        rd_ready = 1'b1;
        b = 0;
        while (rd_valid && b < 2 * DEPTH + 4) begin
            tick();
            b++;
        end
        rd_ready = 1'b0;
        check_eq("drain_empty", rd_valid, 0);
    endtask

    initial begin
        int rel;
        bit armed;
        int pct;

        // Reset
        tick();
        tick();
        check_eq("rst_finish", finish, 0);
        check_eq("rst_valid", rd_valid, 0);
        check_eq("rst_count", count, 0);
        rst = 1'b0;
        tick();

        // Single word: acknowledged one cycle after en is sampled
        en   = 1'b1;
        data = 32'h4865_6C6C;
        done = 1'b0;
        tick();
        check_eq("t1_finish", finish, 1);
        check_eq("t1_valid", rd_valid, 1);
        check_eq("t1_data", rd_data, 32'h4865_6C6C);
        check_eq("t1_eom", rd_eom, 0);
        check_eq("t1_count", count, 1);
        en = 1'b0;
        tick();
        check_eq("t1_finish_once", finish, 0);
        tick();
        drain();

        // Three-word message, EOM on the last
        send_word(32'h0000_0A01, 1'b0);
        send_word(32'h0000_0A02, 1'b0);
        send_word(32'h0000_0A03, 1'b1);
        check_eq("t2_count", count, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_eom", rd_eom, (i == 2));
            check_eq("t2_data", rd_data, 32'h0000_0A01 + i);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        check_eq("t2_count_end", count, 0);
        check_eq("t2_valid_end", rd_valid, 0);

`ifndef PRINT_RX_DROP_EN
        // Full FIFO backpressures the 17th word until a pop frees a slot
        for (int i = 0; i < DEPTH; i++) send_word($urandom, 1'(i % 5 == 4));
        check_eq("t3_count_full", count, DEPTH);
        en   = 1'b1;
        data = 32'h1717_1717;
        done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t3_no_ack", finish, 0);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check_eq("t3_pop_no_ack", finish, 0);
        check_eq("t3_count_pop", count, DEPTH - 1);
        tick();
        check_eq("t3_late_ack", finish, 1);
        check_eq("t3_count_refill", count, DEPTH);
        en = 1'b0;
        tick();
        tick();
        drain();
`endif

        // en held high long after the acknowledge: only one write
        en   = 1'b1;
        data = 32'h4444_0004;
        done = 1'b0;
        tick();
        check_eq("t4_finish", finish, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t4_hold_finish", finish, 0);
            check_eq("t4_hold_count", count, 1);
        end
        en = 1'b0;
        tick();
        tick();
        drain();

        // Reset during the acknowledge cycle, en still held afterwards
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
        en   = 1'b1;
        data = 32'h5555_0006;
        tick();
        check_eq("t5_ack", finish, 1);
        rst = 1'b1;
        tick();
        check_eq("t5_rst_finish", finish, 0);
        check_eq("t5_rst_count", count, 0);
        check_eq("t5_rst_valid", rd_valid, 0);
        rst = 1'b0;
        tick();
        check_eq("t5_reaccept", finish, 1);
        en = 1'b0;
        tick();
        tick();
        drain();

`ifdef PRINT_RX_DROP_EN
        // Full FIFO in drop mode: words acknowledged, discarded, counted
        send_word(32'hCAFE_0001, 1'b0);
        for (int i = 1; i < DEPTH; i++) send_word($urandom, 1'b0);
        for (int i = 0; i < 3; i++) send_word($urandom, 1'b1);
        check_eq("t6_drops", drop_cnt, 3);
        check_eq("t6_count", count, DEPTH);
        check_eq("t6_head", rd_data, 32'hCAFE_0001);
        drain();
`endif

        // Randomized traffic with varying reader speed and occasional reset
        armed = 1'b0;
        rel   = 0;
        for (int i = 0; i < 3000; i++) begin
            case ((i / 400) % 4)
                0: pct = 80;
                1: pct = 10;
                2: pct = 0;
                default: pct = 50;
            endcase
            rd_ready = ($urandom_range(0, 99) < pct);
            rst      = ($urandom_range(0, 399) == 0);
            tick();
            if (en) begin
                if (m_ack) begin
                    armed = 1'b1;
                    rel   = $urandom_range(0, 3);
                end else if (armed) begin
                    if (rel == 0) begin
                        en    = 1'b0;
                        armed = 1'b0;
                    end else begin
                        rel--;
                    end
                end
            end else if ($urandom_range(0, 1) == 1) begin
                en   = 1'b1;
                data = $urandom;
                done = ($urandom_range(0, 3) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
